sd_fifo_tx_filler: RTL and testbench
====================================

SD_FIFO_TX_FILLER -- requirements
Module: sd_fifo_tx_filler

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, number of 32-bit words buffered (power of two, >=2).
REQ-002 SHALL have parameter MEM_OFFSET, default 4, byte address increment per Wishbone word.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port m_wb_adr_o  output  32  Wishbone master address, equal to adr+offset.
REQ-006 SHALL have port m_wb_we_o  output  1  write enable, always 0 (read-only master).
REQ-007 SHALL have port m_wb_dat_i  input  32  read data from memory.
REQ-008 SHALL have port m_wb_cyc_o  output  1  bus cycle.
REQ-009 SHALL have port m_wb_stb_o  output  1  strobe.
REQ-010 SHALL have port m_wb_ack_i  input  1  slave acknowledge.
REQ-011 SHALL have port en  input  1  transfer enable from data master control.
REQ-012 SHALL have port adr  input  32  block base address, stable while en=1.
REQ-013 SHALL have port rd  input  1  serial-side pop request.
REQ-014 SHALL have port dat_o  output  32  FIFO head word (first-word fall-through).
REQ-015 SHALL have port empty  output  1  FIFO holds no words.
REQ-016 SHALL have port full  output  1  FIFO holds FIFO_DEPTH words.

Function
REQ-017 SHALL implement FSM states IDLE, REQ, DONE.
REQ-018 IDLE->REQ SHALL occur when en=1 and FIFO count < FIFO_DEPTH; cyc_o/stb_o SHALL be 1 in the cycle after that condition is sampled.
REQ-019 In REQ, cyc_o and stb_o SHALL stay 1 and m_wb_adr_o SHALL stay constant until ack_i=1.
REQ-020 On ack_i=1 in REQ: m_wb_dat_i SHALL be pushed into the FIFO that edge, offset SHALL advance by MEM_OFFSET, FSM SHALL go to DONE, cyc_o/stb_o SHALL be 0 next cycle.
REQ-021 DONE SHALL last exactly one cycle and return to IDLE (minimum one idle cycle between bus cycles).
REQ-022 At most one bus cycle SHALL be outstanding; a REQ SHALL start only if the FIFO has room for its word.
REQ-023 offset SHALL be 9 bits and wrap modulo 512 (after 0x1FC with MEM_OFFSET=4, next is 0x000).
REQ-024 dat_o SHALL present the oldest word combinationally from storage; rd=1 with empty=0 SHALL remove it at the clock edge.
REQ-025 rd=1 while empty=1 SHALL be ignored (no count/pointer change).
REQ-026 Simultaneous push and pop SHALL leave count unchanged, including when full (pop frees the slot in the same edge).
REQ-027 ack_i outside REQ SHALL be ignored.
REQ-028 en=0 in any state SHALL, next edge: drop cyc_o/stb_o, clear offset to 0, flush FIFO (empty=1), enter IDLE; a concurrent ack_i SHALL be discarded.

Reset
REQ-029 With rst=1 at a clock edge: FSM=IDLE, offset=0, FIFO pointers/count=0, cyc_o=0, stb_o=0, we_o=0, empty=1, full=0; dat_o value is don't-care.
REQ-030 rst mid-cycle SHALL abandon the bus cycle with no push; rst has priority over en.

Structure
REQ-031 FSM state encoding and MEM_OFFSET default SHALL live in the shared SD defines package.
REQ-032 FIFO storage SHALL be a single-clock sub-module sd_tx_sync_fifo (push, pop, q, count, empty, full, flush).

Verification
REQ-033 Reset then en=1, adr=0x1000, ack one cycle after stb -> reads at 0x1000, 0x1004, ... until full=1 after 8 words; no stb while full.
REQ-034 Full FIFO, rd=1 for one cycle -> dat_o advances, full drops, next bus read issued; pop order matches memory order.
REQ-035 Slave delays ack 5 cycles -> adr_o/stb_o stable for all 5, exactly one word pushed.
REQ-036 en=1 with 129 completed reads, rd continuously -> 129th address is adr+0x000 (wrap), no data loss.
REQ-037 Drop en while stb=1 and ack arrives same cycle -> no push, empty=1, offset 0, cyc_o=0 next cycle.
REQ-038 rd=1 on empty FIFO, and rd with push simultaneously at full -> count unchanged/correct, no corruption.

Source files
------------

// File: rtl/sd_fifo_tx_filler_pkg.sv
// sd_fifo_tx_filler_pkg: shared SD defines for the TX FIFO filler (FSM states, address step).
package sd_fifo_tx_filler_pkg;
    typedef enum logic [1:0] {IDLE, REQ, DONE} fill_state_t;
    localparam int MEM_OFFSET_DEF = 4;
endpackage

// File: rtl/sd_tx_sync_fifo.sv
// sd_tx_sync_fifo: single-clock first-word fall-through FIFO with synchronous flush.
module sd_tx_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         d,
    output logic [WIDTH-1:0]         q,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic pop_ok, push_ok;
    assign pop_ok  = pop && !empty;
    // a pop in the same edge frees the slot, so a push at full is still accepted
    assign push_ok = push && (!full || pop_ok);
    assign q     = mem[rp];
    assign empty = count == '0;
    assign full  = count == (AW+1)'(DEPTH);
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= push_ok ? wp + 1'b1 : wp;
            rp    <= pop_ok ? rp + 1'b1 : rp;
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end
    always_ff @(posedge clk) begin
        if (push_ok) mem[wp] <= d;
    end
endmodule

// File: rtl/sd_fifo_tx_filler.sv
// sd_fifo_tx_filler: Wishbone read master that keeps the SD TX FIFO topped up from memory.
module sd_fifo_tx_filler
    import sd_fifo_tx_filler_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int MEM_OFFSET = MEM_OFFSET_DEF
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] m_wb_adr_o,
    output logic        m_wb_we_o,
    input  logic [31:0] m_wb_dat_i,
    output logic        m_wb_cyc_o,
    output logic        m_wb_stb_o,
    input  logic        m_wb_ack_i,
    input  logic        en,
    input  logic [31:0] adr,
    input  logic        rd,
    output logic [31:0] dat_o,
    output logic        empty,
    output logic        full
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    fill_state_t state, state_n;
    logic [8:0] offset;
    logic [CW-1:0] count;
    logic push;
    assign m_wb_we_o  = 1'b0;
    assign m_wb_cyc_o = state == REQ;
    assign m_wb_stb_o = state == REQ;
    assign m_wb_adr_o = adr + {23'd0, offset};
    // an ack that coincides with en dropping is discarded along with the flush
    assign push = state == REQ && m_wb_ack_i && en;
    always_comb begin
        state_n = !en ? IDLE :
                  state == IDLE ? (count < DEPTH_C ? REQ : IDLE) :
                  state == REQ  ? (m_wb_ack_i ? DONE : REQ) : IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            offset <= '0;
        end else begin
            state  <= state_n;
            offset <= !en ? 9'd0 : push ? offset + 9'(MEM_OFFSET) : offset;
        end
    end
    sd_tx_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (!en),
        .push  (push),
        .pop   (rd),
        .d     (m_wb_dat_i),
        .q     (dat_o),
        .count (count),
        .empty (empty),
        .full  (full)
    );
endmodule

// File: tb/tb_sd_fifo_tx_filler.sv
// tb_sd_fifo_tx_filler: randomized bench against a queue-based model of the TX FIFO filler.
module tb_sd_fifo_tx_filler;
    logic clk = 0, rst, en, rd, ack;
    logic [31:0] adr, dat_i, adr_o, dat_o;
    logic we, cyc, stb, empty, full;
    int errors = 0, checks = 0;
    logic [31:0] mq[$];
    int offs = 0, wait_cnt = 0, delay = 0, dmin = 1, dmax = 1, pushes = 0;
    bit busy = 0, cool = 0, stray = 0;

    sd_fifo_tx_filler dut (
        .clk(clk), .rst(rst), .m_wb_adr_o(adr_o), .m_wb_we_o(we), .m_wb_dat_i(dat_i),
        .m_wb_cyc_o(cyc), .m_wb_stb_o(stb), .m_wb_ack_i(ack), .en(en), .adr(adr),
        .rd(rd), .dat_o(dat_o), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // the slave acks after a per-transaction delay, and may glitch ack while idle
    task automatic drive_ack();
        if (busy) ack = wait_cnt >= delay;
        else ack = stray && ($urandom_range(0, 3) == 0);
        dat_i = (busy && ack) ? memf(adr + 32'(offs)) : $urandom();
    endtask

    task automatic update();
        int sz;
        sz = mq.size();
        if (rst || !en) begin
            mq.delete();
            offs = 0; busy = 0; cool = 0; wait_cnt = 0;
        end else begin
            if (rd && sz > 0) void'(mq.pop_front());
            if (busy && ack) begin
                mq.push_back(dat_i);
                offs = (offs + 4) % 512;
                pushes++;
            end
            if (busy) begin
                cool = ack; wait_cnt = ack ? 0 : wait_cnt + 1; busy = !ack;
            end else if (cool) cool = 0;
            else if (sz < 8) begin
                busy = 1; wait_cnt = 0; delay = $urandom_range(dmax, dmin);
            end
        end
    endtask

    task automatic step();
        drive_ack();
        @(negedge clk);
        chk("stb", 32'(stb), 32'(busy));
        chk("cyc", 32'(cyc), 32'(busy));
        chk("we", 32'(we), 0);
        chk("empty", 32'(empty), 32'(mq.size() == 0));
        chk("full", 32'(full), 32'(mq.size() == 8));
        if (busy) chk("adr", adr_o, adr + 32'(offs));
        if (mq.size() > 0) chk("dat", dat_o, mq[0]);
        @(posedge clk);
        update();
        #1;
    endtask

    task automatic wait_busy(input string name);
        int n = 0;
        while (!busy && n < 20) begin step(); n++; end
        if (!busy) chk(name, 0, 1);
    endtask

    initial begin
        int n;
        logic [31:0] a;
        rst = 1; en = 0; rd = 0; ack = 0; adr = 32'h1000; dat_i = 0;
        repeat (2) step();
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_stb", 32'(stb), 0);
        rst = 0; en = 1;
        n = 0;
        while (mq.size() < 8 && n < 200) begin step(); n++; end
        chk("fill_timeout", 32'(mq.size()), 8);
        repeat (10) step();
        chk("fill_full", 32'(full), 1);
        chk("fill_no_stb", 32'(stb), 0);
        chk("fill_head", dat_o, memf(32'h1000));
        chk("model_tail", mq[7], memf(32'h101C));
        rd = 1; step(); rd = 0;
        chk("pop_head", dat_o, memf(32'h1004));
        chk("pop_full", 32'(full), 0);
        repeat (10) step();
        chk("refill_tail", mq[7], memf(32'h1020));
        // slow slave: address and strobe must hold through a five-cycle wait
        en = 0; dmin = 5; dmax = 5; step(); en = 1;
        wait_busy("delay5_start");
        a = adr_o; n = 0;
        while (busy && n < 20) begin
            chk("delay5_adr", adr_o, a);
            step(); n++;
        end
        chk("delay5_cycles", 32'(n), 6);
        chk("delay5_word", 32'(empty), 0);
        chk("delay5_data", dat_o, memf(32'h1000));
        // en dropped in the same cycle the slave acks
        en = 0; dmin = 0; dmax = 0; step(); en = 1;
        wait_busy("drop_start");
        en = 0; step();
        chk("drop_stb", 32'(stb), 0);
        chk("drop_empty", 32'(empty), 1);
        en = 1; step();
        // 129 reads with continuous draining: the 129th address wraps to the base
        en = 0; dmin = 1; dmax = 1; step(); en = 1; rd = 1; pushes = 0;
        n = 0;
        while (pushes < 128 && n < 2000) begin step(); n++; end
        chk("wrap_count", 32'(pushes), 128);
        wait_busy("wrap_start");
        chk("wrap_adr", adr_o, 32'h1000);
        while (busy && n < 2100) begin step(); n++; end
        chk("wrap_data", dat_o, memf(32'h1000));
        rd = 0;
        stray = 1; dmin = 0; dmax = 4;
        for (int i = 0; i < 4000; i++) begin
            rd  = (i % 500 < 250) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
            en  = $urandom_range(0, 99) != 0;
            rst = $urandom_range(0, 299) == 0;
            if (!en) adr = $urandom() & 32'hFFFF_FFFC;
            step();
        end
        rst = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
